// File: rtl/rsa_pkg.sv
// Shared defaults, FSM state encoding and host write-select codes for the RSA host controller.
package rsa_pkg;

    localparam int unsigned DEF_WIDTH  = 4096;
    localparam int unsigned DEF_WORD   = 32;
    localparam int unsigned DEF_NWORDS = DEF_WIDTH / DEF_WORD;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } rsa_state_t;

    typedef enum logic [1:0] {
        SEL_MSG  = 2'd0,
        SEL_EXP  = 2'd1,
        SEL_MOD  = 2'd2,
        SEL_RSVD = 2'd3
    } rsa_sel_t;

endpackage

// File: rtl/rsa_operand_reg.sv
// One WIDTH-bit operand assembled from WORD-sized host writes, LS word first,
// with a wrapping word counter and a flag that is set once the top word lands.
module rsa_operand_reg
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned WORD  = DEF_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [WORD-1:0]  i_data,
    output logic [WIDTH-1:0] o_value,
    output logic             o_loaded
);

    localparam int unsigned NWORDS = WIDTH / WORD;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_value;
    logic             r_loaded;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx    <= '0;
            r_value  <= '0;
            r_loaded <= 1'b0;
        end else if (i_we) begin
            r_value[r_idx*WORD +: WORD] <= i_data;
            if (r_idx == LAST_IDX) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // Set is evaluated last so a single-word operand still ends up loaded.
            if (r_idx == '0) begin
                r_loaded <= 1'b0;
            end
            if (r_idx == LAST_IDX) begin
                r_loaded <= 1'b1;
            end
        end
    end

    assign o_value  = r_value;
    assign o_loaded = r_loaded;

endmodule

// File: rtl/rsa_host_ctrl.sv
// Host-side controller for the rsa4k core: word-wise operand loading, core
// handshake with optional timeout, and word-wise result drain with backpressure.
module rsa_host_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned WORD    = DEF_WORD,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_sel,
    input  logic [WORD-1:0]  wr_data,
    input  logic             start,
    output logic             busy,
    output logic             err,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WORD-1:0]  rd_data,
    output logic             rd_last,
    output logic             core_go,
    output logic [WIDTH-1:0] core_message,
    output logic [WIDTH-1:0] core_exponent,
    output logic [WIDTH-1:0] core_modulus,
    input  logic [WIDTH-1:0] core_cypher,
    input  logic             core_done
);

    localparam int unsigned NWORDS = WIDTH / WORD;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [31:0]      TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    rsa_state_t       r_state;
    rsa_state_t       w_next;
    logic             r_err;
    logic [31:0]      r_cnt;
    logic [IDX_W-1:0] r_index;
    logic [WIDTH-1:0] r_result;

    logic             w_wr_fire;
    logic [2:0]       w_we;
    logic [2:0]       w_loaded;
    logic             w_all_loaded;
    logic             w_timeout;

    assign w_wr_fire    = wr_valid && (r_state == ST_IDLE);
    assign w_we[0]      = w_wr_fire && (wr_sel == SEL_MSG);
    assign w_we[1]      = w_wr_fire && (wr_sel == SEL_EXP);
    assign w_we[2]      = w_wr_fire && (wr_sel == SEL_MOD);
    assign w_all_loaded = &w_loaded;
    assign w_timeout    = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

    rsa_operand_reg #(.WIDTH(WIDTH), .WORD(WORD)) u_msg (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_we[0]),
        .i_data   (wr_data),
        .o_value  (core_message),
        .o_loaded (w_loaded[0])
    );

    rsa_operand_reg #(.WIDTH(WIDTH), .WORD(WORD)) u_exp (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_we[1]),
        .i_data   (wr_data),
        .o_value  (core_exponent),
        .o_loaded (w_loaded[1])
    );

    rsa_operand_reg #(.WIDTH(WIDTH), .WORD(WORD)) u_mod (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_we[2]),
        .i_data   (wr_data),
        .o_value  (core_modulus),
        .o_loaded (w_loaded[2])
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (start && w_all_loaded) w_next = ST_ARM;
            ST_ARM:     if (!core_done) w_next = ST_RUN;
            ST_RUN: begin
                if (core_done) begin
                    w_next = ST_CAPTURE;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_CAPTURE: w_next = ST_DRAIN;
            ST_DRAIN:   if (rd_ready && (r_index == LAST_IDX)) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // core_go is decoded from the state register so it falls with the async reset.
    always_comb begin
        wr_ready = 1'b0;
        core_go  = 1'b0;
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        busy     = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE:  wr_ready = 1'b1;
            ST_RUN:   core_go  = 1'b1;
            ST_DRAIN: begin
                rd_valid = 1'b1;
                rd_last  = (r_index == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_index  <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err <= !w_all_loaded;
                    end
                    if (w_wr_fire && (wr_sel == SEL_RSVD)) begin
                        r_err <= 1'b1;
                    end
                end
                ST_ARM: r_cnt <= '0;
                ST_RUN: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (!core_done && w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_result <= core_cypher;
                    r_index  <= '0;
                end
                ST_DRAIN: begin
                    if (rd_ready) begin
                        r_index <= r_index + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign err     = r_err;
    assign rd_data = r_result[r_index*WORD +: WORD];

endmodule

// File: doc/rsa_host_ctrl.md
RSA_HOST_CTRL -- requirements
Module: rsa_host_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4096, operand/result width in bits.
REQ-002 SHALL have parameter WORD, default 32, host bus word width; NWORDS = WIDTH/WORD (128).
REQ-003 SHALL have parameter TIMEOUT, default 0, maximum core cycles per operation; 0 disables the timeout.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low
wr_valid  in  1  host operand word valid
wr_ready  out  1  operand word accepted when high with wr_valid
wr_sel  in  2  0=message, 1=exponent, 2=modulus, 3=reserved
wr_data  in  WORD  operand word, least-significant word first
start  in  1  one-cycle request to run the core
busy  out  1  high outside IDLE
err  out  1  sticky error flag, cleared by the next accepted start
rd_valid  out  1  result word valid
rd_ready  in  1  host accepts result word
rd_data  out  WORD  result word, least-significant word first
rd_last  out  1  high with word NWORDS-1
core_go  out  1  go level to the rsa4k core
core_message, core_exponent, core_modulus  out  WIDTH each  operands to the core
core_cypher  in  WIDTH  core result
core_done  in  1  core completion level

Function
REQ-006 States: IDLE, ARM, RUN, CAPTURE, DRAIN.
REQ-007 IDLE: wr_ready=1; other states: wr_ready=0.
REQ-008 Each accepted write stores wr_data at bits [k*WORD +: WORD] of the selected operand, where k is that operand's word counter; the counter then increments and wraps from NWORDS-1 to 0.
REQ-009 Writing word 0 clears that operand's loaded flag; writing word NWORDS-1 sets it.
REQ-010 A write with wr_sel=3 is accepted, discarded, and sets err.
REQ-011 Operands and loaded flags persist across operations, so one modulus can be reused.
REQ-012 start in IDLE with all three flags set: clear err, go to ARM. Otherwise in IDLE: set err, stay in IDLE.
REQ-013 start outside IDLE is ignored.
REQ-014 ARM: core_go=0; wait until core_done=0, then go to RUN on the next cycle.
REQ-015 RUN: core_go=1 held steady; the cycle counter increments every cycle.
REQ-016 RUN exits to CAPTURE on core_done=1.
REQ-017 If TIMEOUT>0 and the counter reaches TIMEOUT, RUN sets err, drops core_go, and returns to IDLE with the result unchanged.
REQ-018 CAPTURE lasts one cycle: latch core_cypher into the result register, core_go=0, word index=0, go to DRAIN.
REQ-019 DRAIN: rd_valid=1; rd_data = result word[index]; rd_last = (index==NWORDS-1).
REQ-020 DRAIN: on rd_valid&&rd_ready the index increments; the transfer with rd_last returns the block to IDLE.
REQ-021 rd_data and rd_last SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-022 core_message, core_exponent and core_modulus are driven directly from the operand registers and are stable throughout ARM, RUN and CAPTURE.
REQ-023 Latency: start to core_go=1 is 2 cycles when core_done is low. core_done to first rd_valid is 2 cycles.

Reset
REQ-024 reset low SHALL asynchronously force: IDLE, core_go=0, rd_valid=0, rd_last=0, busy=0, err=0, word counters=0, index=0, loaded flags=0.
REQ-025 Operand and result registers SHALL reset to 0.
REQ-026 Reset mid-RUN SHALL drop core_go within the reset assertion without waiting for core_done.

Structure
REQ-027 Package rsa_pkg SHALL hold WIDTH/WORD/NWORDS defaults, the state enum, and the wr_sel codes.
REQ-028 Sub-module rsa_operand_reg SHALL hold one operand: word counter, loaded flag and WIDTH register. It is instantiated three times.

Verification
REQ-029 Load message=8, exponent=13, modulus=77 (words 1..127 zero), start with rsa4k attached -> 128 words read, word0=0x00000032 (50), others 0, rd_last on word 127.
REQ-030 Rewrite message=50 only, exponent=37, keep modulus, start -> word0=0x00000008, err=0.
REQ-031 start after writing only 127 modulus words -> err=1, busy stays 0, core_go never rises.
REQ-032 rd_ready held low 10 cycles mid-drain -> rd_data/rd_last stable, no words lost or duplicated.
REQ-033 TIMEOUT=50, core model never asserts done -> err=1 at cycle 50 of RUN, core_go=0, back in IDLE.
REQ-034 Reset asserted during RUN -> core_go=0 and busy=0 immediately; loaded flags=0 after release.
